// File: rtl/params_pkg.sv
// Shared widths and types for the multiply pipeline.
// The stage record is sized from these package widths.
package params_pkg;

  localparam int XLEN           = 32;
  localparam int REGISTER_WIDTH = 5;
  localparam int ROB_IDX_WIDTH  = 6;
  localparam int PRODUCT_WIDTH  = 2 * (XLEN + 1);
  localparam int MUL_LATENCY    = 5;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef struct packed {
    logic                      valid;
    mul_op_t                   op;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [ROB_IDX_WIDTH-1:0]  rob_idx;
    logic [PRODUCT_WIDTH-1:0]  product;
  } mul_stage_t;

endpackage

// File: rtl/mul_pipe_slot.sv
// One multiply pipeline stage register. A load takes the new record; a clear
// drops only the valid bit, so the stale wr_reg stays visible to the hazard unit.
module mul_pipe_slot
  import params_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       clear_i,
  input  mul_stage_t d_i,
  output mul_stage_t q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end else if (clear_i) begin
      q_o.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_pipeline.sv
// Five-stage in-order multiply pipeline with local stall and bubble compression.
// Optional MUL_PIPE_PERF_EN adds accept and full-stall counters.
module mul_pipeline
  import params_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int ROB_IDX_WIDTH  = params_pkg::ROB_IDX_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  input  logic                      ex_bubble_i,
  input  logic                      flush_i,
  input  mul_op_t                   issue_op_i,
  input  logic [DATA_WIDTH-1:0]     issue_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     issue_rs2_data_i,
  input  logic [REGISTER_WIDTH-1:0] issue_wr_reg_i,
  input  logic [ROB_IDX_WIDTH-1:0]  issue_rob_idx_i,
  output logic                      issue_ready_o,
  input  logic                      ex_allowed_wb_i,
  output logic                      ex1_valid_o,
  output logic                      ex2_valid_o,
  output logic                      ex3_valid_o,
  output logic                      ex4_valid_o,
  output logic                      ex5_valid_o,
  output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
  output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
  output logic                      wb_valid_o,
  output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
  output logic [ROB_IDX_WIDTH-1:0]  wb_rob_idx_o,
  output logic [DATA_WIDTH-1:0]     wb_result_o
`ifdef MUL_PIPE_PERF_EN
 ,output logic [31:0]               perf_issued_o,
  output logic [31:0]               perf_full_stall_o
`endif
);

  localparam int LAST = MUL_LATENCY - 1;

  mul_stage_t             stage_q [MUL_LATENCY];
  mul_stage_t             stage_d [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] valid;
  logic [MUL_LATENCY-1:0] adv;
  logic [MUL_LATENCY-1:0] free;
  logic [MUL_LATENCY-1:0] load;
  logic [MUL_LATENCY-1:0] clear;
  logic                   accept;

  logic signed [DATA_WIDTH:0]     op_a;
  logic signed [DATA_WIDTH:0]     op_b;
  logic signed [2*DATA_WIDTH+1:0] product;
  logic [DATA_WIDTH-1:0]          result_half;

  // Advance chain: a stage moves when the one ahead is empty or itself moving.
  always_comb begin
    adv  = '0;
    free = '0;
    adv[LAST]  = valid[LAST] & ex_allowed_wb_i;
    free[LAST] = ~valid[LAST] | adv[LAST];
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k]  = valid[k] & free[k+1];
      free[k] = ~valid[k] | adv[k];
    end
  end

  assign issue_ready_o = free[0];
  assign accept        = issue_valid_i & ~ex_bubble_i & ~flush_i & free[0];

  always_comb begin
    op_a = {1'b0, issue_rs1_data_i};
    op_b = {1'b0, issue_rs2_data_i};
    if (issue_op_i == MULH || issue_op_i == MULHSU) begin
      op_a = {issue_rs1_data_i[DATA_WIDTH-1], issue_rs1_data_i};
    end
    if (issue_op_i == MULH) begin
      op_b = {issue_rs2_data_i[DATA_WIDTH-1], issue_rs2_data_i};
    end
    product = op_a * op_b;
  end

  always_comb begin
    result_half = stage_q[LAST-1].product[2*DATA_WIDTH-1:DATA_WIDTH];
    if (stage_q[LAST-1].op == MUL) begin
      result_half = stage_q[LAST-1].product[DATA_WIDTH-1:0];
    end
  end

  // EX5 keeps only the selected half, zero-extended into the product field.
  always_comb begin
    stage_d[0].valid   = 1'b1;
    stage_d[0].op      = issue_op_i;
    stage_d[0].wr_reg  = issue_wr_reg_i;
    stage_d[0].rob_idx = issue_rob_idx_i;
    stage_d[0].product = product;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    stage_d[LAST].product = {{(PRODUCT_WIDTH-DATA_WIDTH){1'b0}}, result_half};
  end

  always_comb begin
    load     = '0;
    clear    = '0;
    load[0]  = accept;
    clear[0] = adv[0];
    for (int k = 1; k < MUL_LATENCY; k++) begin
      load[k]  = adv[k-1];
      clear[k] = adv[k];
    end
  end

  for (genvar g = 0; g < MUL_LATENCY; g++) begin : g_slot
    mul_pipe_slot u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[g]),
      .clear_i (clear[g]),
      .d_i     (stage_d[g]),
      .q_o     (stage_q[g])
    );
    assign valid[g] = stage_q[g].valid;
  end

  assign ex1_valid_o  = valid[0];
  assign ex2_valid_o  = valid[1];
  assign ex3_valid_o  = valid[2];
  assign ex4_valid_o  = valid[3];
  assign ex5_valid_o  = valid[LAST];
  assign ex1_wr_reg_o = stage_q[0].wr_reg;
  assign ex2_wr_reg_o = stage_q[1].wr_reg;
  assign ex3_wr_reg_o = stage_q[2].wr_reg;
  assign ex4_wr_reg_o = stage_q[3].wr_reg;
  assign wb_valid_o   = valid[LAST];
  assign wb_wr_reg_o  = stage_q[LAST].wr_reg;
  assign wb_rob_idx_o = stage_q[LAST].rob_idx;
  assign wb_result_o  = stage_q[LAST].product[DATA_WIDTH-1:0];

  logic unused_ex5;
  assign unused_ex5 = ^{stage_q[LAST].op, stage_q[LAST].product[PRODUCT_WIDTH-1:DATA_WIDTH]};

`ifdef MUL_PIPE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o     <= '0;
      perf_full_stall_o <= '0;
    end else begin
      if (accept) begin
        perf_issued_o <= perf_issued_o + 32'd1;
      end
      if (issue_valid_i && !free[0]) begin
        perf_full_stall_o <= perf_full_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mul_pipeline.md
Name: mul_pipeline

Overview:
- 5-stage in-order multiply execution pipeline (EX1..EX5) fed by decode in parallel with the ALU path.
- Produces the per-stage valid and destination-register signals that the hazard unit consumes. Consumes that unit's ex bubble and flush outputs plus the writeback arbiter's grant.
- Presents one completed multiply per cycle to writeback from EX5.
- Stalls locally and compresses bubbles so that decode backpressure occurs only when all five stages are occupied.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, architectural register index width.
- ROB_IDX_WIDTH, params_pkg::ROB_IDX_WIDTH, reorder-buffer tag width carried with each op.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  decode presents a MUL-class instruction.
- ex_bubble_i  in  1  hazard bubble; when high, the issue is ignored.
- flush_i  in  1  branch/jump flush; when high, the issue is ignored.
- issue_op_i  in  2  mul_op_t: MUL, MULH, MULHSU, MULHU.
- issue_rs1_data_i  in  DATA_WIDTH  operand A.
- issue_rs2_data_i  in  DATA_WIDTH  operand B.
- issue_wr_reg_i  in  REGISTER_WIDTH  destination register.
- issue_rob_idx_i  in  ROB_IDX_WIDTH  ROB tag.
- issue_ready_o  out  1  EX1 can accept this cycle.
- ex_allowed_wb_i  in  1  writeback grant for EX5.
- ex1_valid_o..ex5_valid_o  out  1 each  stage occupancy.
- ex1_wr_reg_o..ex4_wr_reg_o  out  REGISTER_WIDTH each  stage destination register.
- wb_valid_o  out  1  equals ex5_valid_o.
- wb_wr_reg_o  out  REGISTER_WIDTH  EX5 destination register.
- wb_rob_idx_o  out  ROB_IDX_WIDTH  EX5 ROB tag.
- wb_result_o  out  DATA_WIDTH  EX5 result.

Behaviour:
- Reset:
  - All valid outputs are 0.
  - All wr_reg, rob_idx and result registers are 0.
  - issue_ready_o is 1 after reset.
  - An asynchronous reset during operation drops every in-flight op; none of them reaches writeback.
- Accept condition: accept = issue_valid_i && !ex_bubble_i && !flush_i && issue_ready_o.
- Advance chain, evaluated combinationally:
  - adv5 = ex5_valid && ex_allowed_wb_i.
  - free_k = !ex_k_valid || adv_k.
  - adv_k = ex_k_valid && free_(k+1), for k = 1..4.
- issue_ready_o = free_1. This equals !(all five valid && !ex_allowed_wb_i).
- Stage update on each clock:
  - If adv_k, stage k+1 loads stage k.
  - Else, if stage k+1 did not advance (adv_(k+1) = 0), it holds.
  - Else stage k+1 becomes invalid.
  - EX1 loads on accept. Otherwise EX1 holds if !adv1, or clears if adv1.
- Latency: an accepted op appears on wb_valid_o exactly 4 cycles after the accept edge (5 cycles issue-to-WB inclusive), provided there is no stall.
- Bubbles ahead of a stall collapse: an op advances into any empty next stage while EX5 is stalled.
- Arithmetic:
  - Operands are extended to DATA_WIDTH+1 bits: signed for MULH (both operands), signed A / unsigned B for MULHSU, unsigned for MULHU and MUL.
  - The full 2*(DATA_WIDTH+1)-bit product is formed.
  - MUL returns bits [DATA_WIDTH-1:0]. The other ops return bits [2*DATA_WIDTH-1:DATA_WIDTH].
  - The product is computed in EX1. Stages EX2..EX4 carry it (retiming permitted). The half is selected into the EX5 result register.
- Invalid stages still drive their registered wr_reg. The hazard unit qualifies wr_reg with valid.
- Flush semantics: ops already in EX are older than the flushing branch and are never squashed. flush_i only blocks the same-cycle issue.
- Simultaneous events:
  - When EX5 retires and EX1 accepts in the same cycle with the pipe full, everything shifts and no cycle is lost.
  - If ex_allowed_wb_i stays low indefinitely, state holds and the outputs are stable.

Optional Feature:
- Macro: MUL_PIPE_PERF_EN.
- When defined, adds output ports:
  - perf_issued_o (32-bit): count of accepts.
  - perf_full_stall_o (32-bit): cycles with issue_valid_i && !issue_ready_o.
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- params_pkg gains:
  - typedef enum logic [1:0] mul_op_t {MUL, MULH, MULHSU, MULHU}.
  - localparam MUL_LATENCY = 5.
  - typedef struct mul_stage_t {valid, op, wr_reg, rob_idx, product}.
- Sub-module mul_pipe_slot:
  - One stage register holding mul_stage_t, with load/hold/clear control.
  - Five instances are chained by the advance logic in mul_pipeline.

Test Plan:
- Single op: issue MUL 7 * -3 (0x00000007, 0xFFFFFFFD), wr_reg 5, allowed_wb high. Expect ex1..ex5 valid on successive cycles, and wb_result_o = 0xFFFFFFEB with wb_wr_reg_o = 5, 4 cycles after accept.
- High halves: MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF.
- Full stall: issue 5 back-to-back ops with ex_allowed_wb_i low. Expect all valid, issue_ready_o = 0, a 6th op not accepted and stable outputs for 10 cycles. Raise the grant for 1 cycle: exactly one retires and the 6th op is accepted in that same cycle.
- Bubble collapse: issue ops at cycles 0 and 3, with the grant held low from cycle 4. Expect both ops packed into EX5 and EX4 by cycle 6, and issue_ready_o = 1.
- Issue blocked: issue_valid_i with flush_i = 1 (or ex_bubble_i = 1). Expect ex1_valid_o to stay 0, while an op already in EX3 continues to WB.
- Reset mid-flight: assert rst_ni low asynchronously with 3 ops in flight. Expect all valids 0 immediately and no wb_valid_o after reset release.
